// File: rtl/gigatron_pkg.sv
// Shared encodings for the Gigatron-compatible core.
// Opcode, addressing mode, bus source and branch condition fields of the IR byte
// IR = {op[2:0], mode[2:0], bus[1:0]}; the reset IR is a harmless "ld ac".
package gigatron_pkg;

  typedef enum logic [2:0] {
    OP_LD  = 3'd0,
    OP_AND = 3'd1,
    OP_OR  = 3'd2,
    OP_XOR = 3'd3,
    OP_ADD = 3'd4,
    OP_SUB = 3'd5,
    OP_ST  = 3'd6,
    OP_BCC = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    MODE_D_AC      = 3'd0,
    MODE_X_AC      = 3'd1,
    MODE_YD_AC     = 3'd2,
    MODE_YX_AC     = 3'd3,
    MODE_D_X       = 3'd4,
    MODE_D_Y       = 3'd5,
    MODE_D_OUT     = 3'd6,
    MODE_YXINC_OUT = 3'd7
  } mode_e;

  typedef enum logic [1:0] {
    BUS_D   = 2'd0,
    BUS_RAM = 2'd1,
    BUS_AC  = 2'd2,
    BUS_IN  = 2'd3
  } bus_e;

  typedef enum logic [2:0] {
    BR_JMP = 3'd0,
    BR_GT  = 3'd1,
    BR_LT  = 3'd2,
    BR_NE  = 3'd3,
    BR_EQ  = 3'd4,
    BR_GE  = 3'd5,
    BR_LE  = 3'd6,
    BR_BRA = 3'd7
  } cond_e;

  localparam logic [7:0] IR_RESET = 8'h02;

endpackage

// File: rtl/gigatron_alu.sv
// Combinational ALU: 8-bit result from opcode/AC/bus, plus branch-taken flag.
// Ports: op_i (IR[7:5]), cond_i (IR[4:2]), ac_i, bus_i -> result_o, taken_o.
// taken_o is only meaningful for OP_BCC; conditions treat AC as signed.
module gigatron_alu
  import gigatron_pkg::*;
(
  input  logic [2:0] op_i,
  input  logic [2:0] cond_i,
  input  logic [7:0] ac_i,
  input  logic [7:0] bus_i,
  output logic [7:0] result_o,
  output logic       taken_o
);

  logic ac_zero;
  logic ac_neg;

  assign ac_zero = (ac_i == 8'h00);
  assign ac_neg  = ac_i[7];

  always_comb begin
    result_o = ac_i;
    case (op_i)
      OP_LD:   result_o = bus_i;
      OP_AND:  result_o = ac_i & bus_i;
      OP_OR:   result_o = ac_i | bus_i;
      OP_XOR:  result_o = ac_i ^ bus_i;
      OP_ADD:  result_o = ac_i + bus_i;
      OP_SUB:  result_o = ac_i - bus_i;
      default: result_o = ac_i;  // ST and Bcc pass AC through
    endcase
  end

  always_comb begin
    taken_o = 1'b0;
    case (cond_i)
      BR_JMP:  taken_o = 1'b1;
      BR_GT:   taken_o = !ac_neg && !ac_zero;
      BR_LT:   taken_o = ac_neg;
      BR_NE:   taken_o = !ac_zero;
      BR_EQ:   taken_o = ac_zero;
      BR_GE:   taken_o = !ac_neg;
      BR_LE:   taken_o = ac_neg || ac_zero;
      default: taken_o = 1'b1;   // BRA
    endcase
  end

endmodule

// File: rtl/gigatron_core.sv
// Gigatron-compatible 8-bit CPU core: 2-stage fetch/execute, one branch delay slot.
// Ports: i_clock/i_reset, ROM fetch (o_rom_addr, i_rom_data, i_rom_valid), i_in,
// o_out/o_xout/o_ctrl peripheral latches, o_retire step pulse. Optional: GIGATRON_CTRL_EN.
module gigatron_core
  import gigatron_pkg::*;
#(
  parameter int RAM_ADDR_WIDTH = 15,
  parameter int ROM_ADDR_WIDTH = 16
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  output logic [ROM_ADDR_WIDTH-1:0] o_rom_addr,
  input  logic [15:0]               i_rom_data,
  input  logic                      i_rom_valid,
  input  logic [7:0]                i_in,
  output logic [7:0]                o_out,
  output logic [7:0]                o_xout,
  output logic [7:0]                o_ctrl,
  output logic                      o_retire
);

  logic [15:0] pc_q, pc_d;
  logic [7:0]  ir_q, ir_d, d_q, d_d;
  logic [7:0]  ac_q, ac_d, x_q, x_d, y_q, y_d;
  logic [7:0]  out_q, out_d, xout_q, xout_d, in_q, in_d, ctrl_q, ctrl_d;
  logic        retire_q;

  logic [7:0] mem_q [0:(2**RAM_ADDR_WIDTH)-1];

  logic [2:0] op, mode;
  logic [1:0] bus_sel;
  logic       is_bcc, is_st, out_wr, ram_we;
  logic [7:0] addr_lo, addr_hi, bus_val, alu_res;
  logic       taken;
  logic [RAM_ADDR_WIDTH-1:0] ram_addr;

  assign op      = ir_q[7:5];
  assign mode    = ir_q[4:2];
  assign bus_sel = ir_q[1:0];
  assign is_bcc  = (op == OP_BCC);
  assign is_st   = (op == OP_ST);

  // Branches always address [0:D]; otherwise the mode picks X and/or Y.
  always_comb begin
    addr_lo = d_q;
    addr_hi = 8'h00;
    if (!is_bcc) begin
      if (mode == MODE_X_AC || mode == MODE_YX_AC || mode == MODE_YXINC_OUT)
        addr_lo = x_q;
      if (mode == MODE_YD_AC || mode == MODE_YX_AC || mode == MODE_YXINC_OUT)
        addr_hi = y_q;
    end
  end

  // Truncation gives the upper-half mirror when RAM is smaller than 64 KiB.
  assign ram_addr = RAM_ADDR_WIDTH'({addr_hi, addr_lo});

  always_comb begin
    bus_val = d_q;
    case (bus_sel)
      BUS_D:   bus_val = d_q;
      BUS_RAM: bus_val = mem_q[ram_addr];
      BUS_AC:  bus_val = ac_q;
      default: bus_val = in_q;
    endcase
  end

  gigatron_alu u_alu (
    .op_i     (op),
    .cond_i   (mode),
    .ac_i     (ac_q),
    .bus_i    (bus_val),
    .result_o (alu_res),
    .taken_o  (taken)
  );

  // OUT is written only by non-store, non-branch instructions in modes 6/7.
  assign out_wr = !is_bcc && !is_st && (mode == MODE_D_OUT || mode == MODE_YXINC_OUT);

  // ST with bus=RAM never writes memory (it is the ctrl instruction when enabled).
  assign ram_we = i_rom_valid && !i_reset && is_st && (bus_sel != BUS_RAM);

  always_comb begin
    pc_d   = pc_q + 16'd1;
    ir_d   = i_rom_data[7:0];
    d_d    = i_rom_data[15:8];
    ac_d   = ac_q;
    x_d    = x_q;
    y_d    = y_q;
    out_d  = out_q;
    xout_d = xout_q;
    in_d   = in_q;
    ctrl_d = ctrl_q;

    if (is_bcc) begin
      if (taken) begin
        if (mode == BR_JMP) pc_d = {y_q, bus_val};
        else                pc_d = {pc_q[15:8], bus_val};
      end
    end else begin
      case (mode)
        MODE_D_X: x_d = alu_res;
        MODE_D_Y: y_d = alu_res;
        MODE_D_OUT, MODE_YXINC_OUT: if (!is_st) out_d = alu_res;
        default:  if (!is_st) ac_d = alu_res;
      endcase
      if (mode == MODE_YXINC_OUT) x_d = x_q + 8'd1;
`ifdef GIGATRON_CTRL_EN
      if (is_st && bus_sel == BUS_RAM) ctrl_d = addr_lo;
`endif
    end

    // Peripheral latches fire only on rising edges of OUT[6]/OUT[7].
    if (out_wr && !out_q[6] && alu_res[6]) xout_d = ac_q;
    if (out_wr && !out_q[7] && alu_res[7]) in_d   = i_in;
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      pc_q     <= 16'h0000;
      ir_q     <= IR_RESET;
      d_q      <= 8'h00;
      ac_q     <= 8'h00;
      x_q      <= 8'h00;
      y_q      <= 8'h00;
      out_q    <= 8'h00;
      xout_q   <= 8'h00;
      in_q     <= 8'h00;
      ctrl_q   <= 8'h00;
      retire_q <= 1'b0;
    end else begin
      retire_q <= i_rom_valid;
      if (i_rom_valid) begin
        pc_q   <= pc_d;
        ir_q   <= ir_d;
        d_q    <= d_d;
        ac_q   <= ac_d;
        x_q    <= x_d;
        y_q    <= y_d;
        out_q  <= out_d;
        xout_q <= xout_d;
        in_q   <= in_d;
        ctrl_q <= ctrl_d;
      end
    end
  end

  // RAM contents survive reset; the write is simply suppressed while reset is high.
  always_ff @(posedge i_clock) begin
    if (ram_we) mem_q[ram_addr] <= bus_val;
  end

  assign o_rom_addr = ROM_ADDR_WIDTH'(pc_q);
  assign o_out      = out_q;
  assign o_xout     = xout_q;
  assign o_ctrl     = ctrl_q;
  assign o_retire   = retire_q;

endmodule
